priority_irq_encoder: RTL

PRIORITY_IRQ_ENCODER -- requirements
Module: priority_irq_encoder

---
 rtl/priority_irq_encoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/priority_irq_encoder.sv
// priority_irq_encoder: sticky interrupt request capture with a registered
// grant/acknowledge handshake.
//
// Active-low requests (iReq) are latched into a sticky pending register.
// When enabled (iEI low), the block selects one unmasked pending line and
// holds it as a grant (oValid/oCode) until the consumer pulses iAck.
//
// Configuration macro PRI_ROTATE_EN:
//   undefined : fixed priority, index N-1 highest.
//   defined   : rotating priority. After granting index k, the search starts
//               at (k-1) mod N and descends with wrap-around.
//
// Ports:
//   iClk      clock, rising edge
//   iRst      synchronous active-high reset
//   iReq      [N-1:0] active-low request lines
//   iEI       active-low enable for new grants
//   iMask     [N-1:0] 1 = line not selectable (still recorded as pending)
//   iAck      grant acknowledge, ignored while oValid is low
//   oValid    grant valid
//   oCode     [IDX_W-1:0] granted line index
//   oPending  [N-1:0] raw sticky pending register
//   oEO       enable-out: enabled, idle, and nothing selectable
module priority_irq_encoder #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [N-1:0]     iReq,
    input  logic             iEI,
    input  logic [N-1:0]     iMask,
    input  logic             iAck,
    output logic             oValid,
    output logic [IDX_W-1:0] oCode,
    output logic [N-1:0]     oPending,
    output logic             oEO
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_pending;
    logic [N-1:0]     w_pending_nxt;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_sel;
    logic             w_any;
    logic [IDX_W-1:0] r_code;
    logic [IDX_W-1:0] w_code_nxt;
    logic [IDX_W-1:0] w_pick;
    logic             r_valid;
    logic             w_valid_nxt;

    // Lines eligible for selection this cycle
    assign w_sel = r_pending & ~iMask;
    assign w_any = |w_sel;

`ifdef PRI_ROTATE_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_pick_lo;
    logic [IDX_W-1:0] w_pick_hi;
    logic             w_any_lo;

    // Descending search from r_ptr with wrap: lines at or below the pointer
    // outrank lines above it; within each group the highest index wins.
    always_comb begin
        w_pick_lo = '0;
        w_pick_hi = '0;
        w_any_lo  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_sel[i]) begin
                if (i <= int'(r_ptr)) begin
                    w_pick_lo = IDX_W'(i);
                    w_any_lo  = 1'b1;
                end else begin
                    w_pick_hi = IDX_W'(i);
                end
            end
        end
        w_pick = w_any_lo ? w_pick_lo : w_pick_hi;
    end
`else
    // Fixed priority: highest selectable index wins
    always_comb begin
        w_pick = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_sel[i]) begin
                w_pick = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state, grant and pending update
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_clr       = '0;
`ifdef PRI_ROTATE_EN
        w_ptr_nxt   = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (!iEI && w_any) begin
                    w_state_nxt = GRANT;
                    w_code_nxt  = w_pick;
                    w_valid_nxt = 1'b1;
`ifdef PRI_ROTATE_EN
                    w_ptr_nxt   = (w_pick == '0) ? IDX_W'(N - 1) : (w_pick - 1'b1);
`endif
                end
            end
            GRANT: begin
                if (iAck) begin
                    w_clr       = N'(1) << r_code;
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        // A request on the same edge as its ack re-sets the bit
        w_pending_nxt = (r_pending & ~w_clr) | ~iReq;
    end

    // State register; reset overrides set, ack and grant
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
`ifdef PRI_ROTATE_EN
            r_ptr     <= IDX_W'(N - 1);
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
`ifdef PRI_ROTATE_EN
            r_ptr     <= w_ptr_nxt;
`endif
        end
    end

    assign oValid   = r_valid;
    assign oCode    = r_code;
    assign oPending = r_pending;
    // Registered state combined with the live enable and mask
    assign oEO      = ~iEI & (r_state == IDLE) & ~w_any;

endmodule
